// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 instruction-fetch controller.
package lc3_pkg;

  typedef enum logic [2:0] {
    S_HALTED = 3'd0,
    S_FETCH1 = 3'd1,
    S_FETCH2 = 3'd2,
    S_FETCH3 = 3'd3,
    S_PAUSE1 = 3'd4,
    S_PAUSE2 = 3'd5
  } fetch_state_t;

  localparam int MEM_WAIT_DEFAULT = 2;

  typedef struct packed {
    logic gatepc;
    logic gatemdr;
    logic ld_mar;
    logic ld_mdr;
    logic ld_ir;
    logic ld_pc;
    logic mio_en;
    logic pcmux_en;
    logic mem_ce_n;
    logic mem_oe_n;
    logic mem_we_n;
  } ctrl_t;

  // No loads, no bus drivers, SRAM strobes inactive.
  localparam ctrl_t CTRL_IDLE = '{
    gatepc:   1'b0,
    gatemdr:  1'b0,
    ld_mar:   1'b0,
    ld_mdr:   1'b0,
    ld_ir:    1'b0,
    ld_pc:    1'b0,
    mio_en:   1'b0,
    pcmux_en: 1'b0,
    mem_ce_n: 1'b1,
    mem_oe_n: 1'b1,
    mem_we_n: 1'b1
  };

endpackage

// File: rtl/fetch_control_wait_counter.sv
// 4-bit memory-wait counter with synchronous clear, enable and terminal count.
module wait_counter #(
  parameter int MEM_WAIT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [3:0] TC_VAL = 4'(MEM_WAIT - 1);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 4'd0;
    end else if (en_i) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/fetch_control.sv
// Fetch-sequencing FSM: MAR<=PC/PC<=PC+1, memory read, IR<=MDR, then pause for Continue.
module fetch_control
  import lc3_pkg::*;
#(
  parameter int MEM_WAIT = MEM_WAIT_DEFAULT,
  parameter int CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             Continue,
  output logic             GATEPC,
  output logic             GATEMDR,
  output logic             LD_MAR,
  output logic             LD_MDR,
  output logic             LD_IR,
  output logic             LD_PC,
  output logic             MIO_EN,
  output logic             PCMUX_EN,
  output logic             Mem_CE_N,
  output logic             Mem_OE_N,
  output logic             Mem_WE_N,
  output logic [CNT_W-1:0] Fetch_Count,
  output logic [2:0]       State
);

  fetch_state_t     state_q;
  fetch_state_t     state_d;
  logic [CNT_W-1:0] fetch_count_q;
  logic [CNT_W-1:0] fetch_count_d;
  logic             wait_tc;
  ctrl_t            ctrl;

  wait_counter #(
    .MEM_WAIT (MEM_WAIT)
  ) u_wait_counter (
    .clk   (Clk),
    .rst_n (Reset),
    .clr_i (state_q == S_FETCH1),
    .en_i  (state_q == S_FETCH2),
    .tc_o  (wait_tc)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= S_HALTED;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Every FETCH3 cycle is exactly one IR load, and FETCH3 always exits.
  assign fetch_count_d = (state_q == S_FETCH3) ? fetch_count_q + 1'b1 : fetch_count_q;

  always_comb begin
    state_d = state_q;
    ctrl    = CTRL_IDLE;
    case (state_q)
      S_HALTED: begin
        if (Run) state_d = S_FETCH1;
      end
      S_FETCH1: begin
        ctrl.gatepc   = 1'b1;
        ctrl.ld_mar   = 1'b1;
        ctrl.ld_pc    = 1'b1;
        ctrl.pcmux_en = 1'b1;
        state_d       = S_FETCH2;
      end
      S_FETCH2: begin
        ctrl.mem_ce_n = 1'b0;
        ctrl.mem_oe_n = 1'b0;
        ctrl.mio_en   = 1'b1;
        ctrl.ld_mdr   = wait_tc;
        if (wait_tc) state_d = S_FETCH3;
      end
      S_FETCH3: begin
        ctrl.gatemdr = 1'b1;
        ctrl.ld_ir   = 1'b1;
        state_d      = S_PAUSE1;
      end
      S_PAUSE1: begin
        if (Continue) state_d = S_PAUSE2;
      end
      S_PAUSE2: begin
        // Waiting for release gives one fetch per press.
        if (!Continue) state_d = S_FETCH1;
      end
      default: begin
        state_d = S_HALTED;
      end
    endcase
  end

  assign GATEPC      = ctrl.gatepc;
  assign GATEMDR     = ctrl.gatemdr;
  assign LD_MAR      = ctrl.ld_mar;
  assign LD_MDR      = ctrl.ld_mdr;
  assign LD_IR       = ctrl.ld_ir;
  assign LD_PC       = ctrl.ld_pc;
  assign MIO_EN      = ctrl.mio_en;
  assign PCMUX_EN    = ctrl.pcmux_en;
  assign Mem_CE_N    = ctrl.mem_ce_n;
  assign Mem_OE_N    = ctrl.mem_oe_n;
  assign Mem_WE_N    = ctrl.mem_we_n;
  assign Fetch_Count = fetch_count_q;
  assign State       = state_q;

endmodule

// File: tb/tb_fetch_control.sv
// Bench for fetch_control: MEM_WAIT=2 and MEM_WAIT=1 instances against a fetch-phase model.
module tb_fetch_control;

  logic Clk      = 1'b0;
  logic Reset    = 1'b0;
  logic Run      = 1'b0;
  logic Continue = 1'b0;

  always #5 Clk = ~Clk;

  // Index 0: MEM_WAIT=2 instance, index 1: MEM_WAIT=1 instance.
  logic        gatepc[2], gatemdr[2], ld_mar[2], ld_mdr[2], ld_ir[2], ld_pc[2];
  logic        mio_en[2], pcmux_en[2], mem_ce_n[2], mem_oe_n[2], mem_we_n[2];
  logic [15:0] fcount[2];
  logic [2:0]  state[2];

  fetch_control #(.MEM_WAIT(2), .CNT_W(16)) dut2 (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
    .GATEPC(gatepc[0]), .GATEMDR(gatemdr[0]), .LD_MAR(ld_mar[0]), .LD_MDR(ld_mdr[0]),
    .LD_IR(ld_ir[0]), .LD_PC(ld_pc[0]), .MIO_EN(mio_en[0]), .PCMUX_EN(pcmux_en[0]),
    .Mem_CE_N(mem_ce_n[0]), .Mem_OE_N(mem_oe_n[0]), .Mem_WE_N(mem_we_n[0]),
    .Fetch_Count(fcount[0]), .State(state[0])
  );

  fetch_control #(.MEM_WAIT(1), .CNT_W(16)) dut1 (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
    .GATEPC(gatepc[1]), .GATEMDR(gatemdr[1]), .LD_MAR(ld_mar[1]), .LD_MDR(ld_mdr[1]),
    .LD_IR(ld_ir[1]), .LD_PC(ld_pc[1]), .MIO_EN(mio_en[1]), .PCMUX_EN(pcmux_en[1]),
    .Mem_CE_N(mem_ce_n[1]), .Mem_OE_N(mem_oe_n[1]), .Mem_WE_N(mem_we_n[1]),
    .Fetch_Count(fcount[1]), .State(state[1])
  );

  int checks = 0;
  int errors = 0;

  // Model: mode 0 halted, 1 fetching (k = cycles since fetch start), 2 await press, 3 await release.
  int          mmode[2];
  int          mk[2];
  logic [15:0] mfetch[2];
  logic [15:0] bias[2];

  function automatic int mw_of(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  always @(posedge Clk or negedge Reset) begin
    for (int i = 0; i < 2; i++) begin
      if (!Reset) begin
        mmode[i]  <= 0;
        mk[i]     <= 0;
        mfetch[i] <= 16'd0;
      end else begin
        case (mmode[i])
          0: if (Run) begin mmode[i] <= 1; mk[i] <= 0; end
          1: begin
            if (mk[i] == mw_of(i) + 1) begin
              mfetch[i] <= mfetch[i] + 16'd1;
              mmode[i]  <= 2;
            end else begin
              mk[i] <= mk[i] + 1;
            end
          end
          2: if (Continue) mmode[i] <= 3;
          default: if (!Continue) begin mmode[i] <= 1; mk[i] <= 0; end
        endcase
      end
    end
  end

  function automatic logic [2:0] exp_state(int mode, int k, int mw);
    if (mode == 0) return 3'd0;
    if (mode == 2) return 3'd4;
    if (mode == 3) return 3'd5;
    if (k == 0) return 3'd1;
    if (k <= mw) return 3'd2;
    return 3'd3;
  endfunction

  // Bit order: gatepc gatemdr ld_mar ld_mdr ld_ir ld_pc mio_en pcmux_en ce_n oe_n we_n
  function automatic logic [10:0] exp_ctrl(int mode, int k, int mw);
    logic gp = 1'b0, gm = 1'b0, lmar = 1'b0, lmdr = 1'b0, lir = 1'b0, lpc = 1'b0;
    logic mio = 1'b0, pcm = 1'b0, ce = 1'b1, oe = 1'b1;
    if (mode == 1) begin
      if (k == 0) begin
        gp = 1'b1; lmar = 1'b1; lpc = 1'b1; pcm = 1'b1;
      end else if (k <= mw) begin
        ce = 1'b0; oe = 1'b0; mio = 1'b1; lmdr = (k == mw);
      end else begin
        gm = 1'b1; lir = 1'b1;
      end
    end
    return {gp, gm, lmar, lmdr, lir, lpc, mio, pcm, ce, oe, 1'b1};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      logic [10:0] act_ctrl;
      logic [15:0] exp_cnt;
      act_ctrl = {gatepc[i], gatemdr[i], ld_mar[i], ld_mdr[i], ld_ir[i], ld_pc[i],
                  mio_en[i], pcmux_en[i], mem_ce_n[i], mem_oe_n[i], mem_we_n[i]};
      exp_cnt  = mfetch[i] + bias[i];
      chk($sformatf("state[%0d]", i), 32'(state[i]), 32'(exp_state(mmode[i], mk[i], mw_of(i))));
      chk($sformatf("ctrl[%0d]", i), 32'(act_ctrl), 32'(exp_ctrl(mmode[i], mk[i], mw_of(i))));
      chk($sformatf("count[%0d]", i), 32'(fcount[i]), 32'(exp_cnt));
      chk($sformatf("bus_excl[%0d]", i), 32'(gatepc[i] & gatemdr[i]), 32'd0);
      chk($sformatf("we_n[%0d]", i), 32'(mem_we_n[i]), 32'd1);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
    compare_all();
  endtask

  int exp_tr2[5] = '{1, 2, 2, 3, 4};
  int exp_tr1[5] = '{1, 2, 3, 4, 4};

  initial begin
    int   oe_low;
    int   f1_seen;
    bit   found;
    logic [4:0] mdr2_mask, mdr1_mask, ce1_mask;

    bias[0] = 16'd0;
    bias[1] = 16'd0;

    // Reset then idle
    repeat (3) tick();
    Reset = 1'b1;
    repeat (10) tick();
    chk("idle_state", 32'(state[0]), 32'd0);
    chk("idle_count", 32'(fcount[0]), 32'd0);
    chk("idle_oe_n", 32'(mem_oe_n[0]), 32'd1);

    // Single fetch with literal trace expectations
    oe_low = 0; mdr2_mask = '0; mdr1_mask = '0; ce1_mask = '0;
    Run = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      Run = 1'b0;
      chk($sformatf("trace2[%0d]", j), 32'(state[0]), 32'(exp_tr2[j]));
      chk($sformatf("trace1[%0d]", j), 32'(state[1]), 32'(exp_tr1[j]));
      if (!mem_oe_n[0]) oe_low++;
      mdr2_mask[j] = ld_mdr[0];
      mdr1_mask[j] = ld_mdr[1];
      ce1_mask[j]  = ~mem_ce_n[1];
    end
    chk("oe_low_cycles", 32'(oe_low), 32'd2);
    chk("ld_mdr2_pos", 32'(mdr2_mask), 32'b00100);
    chk("ld_mdr1_pos", 32'(mdr1_mask), 32'b00010);
    chk("ce1_pos", 32'(ce1_mask), 32'b00010);
    chk("count_after_1", 32'(fcount[0]), 32'd1);

    // Continue held 20 cycles: no fetch until release, then exactly one
    Continue = 1'b1;
    f1_seen = 0;
    repeat (20) begin tick(); if (state[0] == 3'd1) f1_seen++; end
    chk("fetch1_during_hold", 32'(f1_seen), 32'd0);
    Continue = 1'b0;
    f1_seen = 0;
    repeat (10) begin tick(); if (state[0] == 3'd1) f1_seen++; end
    chk("fetch1_after_release", 32'(f1_seen), 32'd1);
    chk("count_after_2", 32'(fcount[0]), 32'd2);
    chk("count1_after_2", 32'(fcount[1]), 32'd2);

    // Counter wrap: preload 0xFFFF into the MEM_WAIT=2 instance
    force dut2.fetch_count_q = 16'hFFFF;
    bias[0] = 16'hFFFF - mfetch[0];
    tick();
    release dut2.fetch_count_q;
    Continue = 1'b1;
    tick();
    Continue = 1'b0;
    repeat (10) tick();
    chk("count_wrap", 32'(fcount[0]), 32'd0);
    chk("count1_after_3", 32'(fcount[1]), 32'd3);

    // Asynchronous reset in the second FETCH2 cycle
    Continue = 1'b1;
    tick();
    Continue = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (state[0] == 3'd2) begin found = 1'b1; break; end
    end
    chk("reach_fetch2", 32'(found), 32'd1);
    @(posedge Clk);
    #3;
    Reset   = 1'b0;
    bias[0] = 16'd0;
    bias[1] = 16'd0;
    #1;
    chk("async_rst_state", 32'(state[0]), 32'd0);
    chk("async_rst_oe_n", 32'(mem_oe_n[0]), 32'd1);
    chk("async_rst_ce_n", 32'(mem_ce_n[0]), 32'd1);
    chk("async_rst_count", 32'(fcount[0]), 32'd0);
    @(negedge Clk);
    compare_all();
    Reset = 1'b1;
    tick();

    // Random Run/Continue traffic
    repeat (300) begin
      Run      = ($urandom_range(0, 3) == 0);
      Continue = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_control.md
Name: fetch_control

Overview:
- Control FSM that sequences the instruction-fetch datapath: MAR<=PC, PC<=PC+1, MDR<=M[MAR], IR<=MDR, then pauses for the user.
- Sits directly upstream of the fetch datapath and drives all of its gate, load and mux-select inputs.
- Also drives the active-low SRAM strobes and reports the fetch count and state for the hex displays.
- Fetch only: no decode or execute. Memory writes are never issued.

Parameters:
- MEM_WAIT, 2: number of cycles the FSM holds the memory-read state before MDR is loaded. Legal range 1..15.
- CNT_W, 16: width of Fetch_Count.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Run  in  1  level; starts fetching from HALTED.
- Continue  in  1  level; releases the post-fetch pause.
- GATEPC  out  1  drive PC onto the bus.
- GATEMDR  out  1  drive MDR onto the bus.
- LD_MAR  out  1  load MAR.
- LD_MDR  out  1  load MDR.
- LD_IR  out  1  load IR.
- LD_PC  out  1  load PC.
- MIO_EN  out  1  MDR input select; 1 selects memory data.
- PCMUX_EN  out  1  PC mux select; 1 selects PC+1.
- Mem_CE_N  out  1  SRAM chip enable, active-low.
- Mem_OE_N  out  1  SRAM output enable, active-low.
- Mem_WE_N  out  1  SRAM write enable, active-low; tied to 1.
- Fetch_Count  out  CNT_W  number of completed IR loads.
- State  out  3  encoded current state, for debug and hex display.

Behaviour:
- Reset (Reset=0, asynchronous):
  - State=HALTED; wait counter=0; Fetch_Count=0.
  - All gate/load/select outputs=0; Mem_CE_N=Mem_OE_N=Mem_WE_N=1.
- Outputs are Moore-decoded from the state register. Each output is valid in the same cycle the state is entered. No glitches between states: decode from registered state only.
- At most one of GATEPC and GATEMDR is 1 in any cycle (bus exclusivity). This is a hard invariant.
- HALTED (0): all outputs idle. Run=1 -> FETCH1, else stay.
- FETCH1 (1): GATEPC=1, LD_MAR=1, LD_PC=1, PCMUX_EN=1. Always -> FETCH2 after one cycle. Clear the wait counter.
- FETCH2 (2):
  - Asserted every cycle in this state: Mem_CE_N=0, Mem_OE_N=0, MIO_EN=1.
  - Wait counter increments each cycle.
  - LD_MDR=1 only in the last cycle, when counter==MEM_WAIT-1.
  - Exit to FETCH3 after exactly MEM_WAIT cycles.
  - MEM_WAIT=1 gives a single cycle with LD_MDR=1.
- FETCH3 (3): GATEMDR=1, LD_IR=1. Fetch_Count increments by 1 on leaving, wrapping modulo 2^CNT_W. -> PAUSE1.
- PAUSE1 (4): idle outputs. Continue=1 -> PAUSE2, else stay.
- PAUSE2 (5): idle outputs. Continue=0 -> FETCH1, else stay. Exactly one fetch per Continue press regardless of hold length.
- Run is sampled only in HALTED. Deasserting Run mid-fetch has no effect.
- Continue is ignored outside PAUSE1/PAUSE2.
- If Continue is already high on entry to PAUSE1, advance to PAUSE2 next cycle. The FSM then waits for release.
- Unused encodings (6,7) -> HALTED next cycle, with idle outputs.
- Reset asserted in any state, including mid-FETCH2, aborts immediately. Memory strobes deassert asynchronously. The counter clears.
- Total latency from Run=1 (sampled in HALTED) to LD_IR=1: 1+1+MEM_WAIT cycles. IR is updated on the edge ending FETCH3.

Decomposition:
- lc3_pkg holds:
  - the fetch_state_t enum (3-bit, values above);
  - MEM_WAIT_DEFAULT;
  - the idle control-word constant (all loads 0, strobes 1).
- One natural sub-module: wait_counter. It is a 4-bit up-counter with sync clear, enable, and a terminal-count output compared to MEM_WAIT-1.
- The FSM and output decode stay in fetch_control.

Test Plan:
- Reset then idle: Reset=0 for 3 cycles, then release with Run=0 for 10 cycles -> State=0 throughout, all loads 0, Mem_CE_N=Mem_OE_N=Mem_WE_N=1, Fetch_Count=0.
- Single fetch, MEM_WAIT=2: Run=1 -> states 1,2,2,3,4 on successive cycles.
  - LD_MDR=1 only in the second FETCH2 cycle.
  - Mem_OE_N=0 for exactly 2 cycles.
  - Fetch_Count=1 in PAUSE1.
- Continue handshake: hold Continue=1 for 20 cycles, then 0 -> exactly one FETCH1 follows the release; Fetch_Count=2 after the second fetch.
- MEM_WAIT=1 build: one fetch -> FETCH2 lasts 1 cycle with LD_MDR=1 and Mem_CE_N=0 in the same cycle.
- Reset mid-operation: Reset=0 asynchronously in the second FETCH2 cycle -> Mem_OE_N=1 and State=0 before the next edge; Fetch_Count=0.
- Invariants across a 300-cycle random Run/Continue run:
  - GATEPC and GATEMDR never both 1.
  - Mem_WE_N always 1.
  - Fetch_Count wraps 0xFFFF->0x0000 after preloading via force.
